// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory responder: access sizes, rw direction,
// handshake FSM states and the big-endian byte-lane helpers.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Reserved size is folded in here so the caller only adds the range check.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = lsb[0];
            SZ_WORD: misaligned = |lsb;
            default: misaligned = 1'b1;
        endcase
    endfunction

    // Bit 3 of the mask is the byte at the lowest address (big-endian).
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: lane_mask = 4'b1000 >> off;
            SZ_HALF: lane_mask = off[1] ? 4'b0011 : 4'b1100;
            SZ_WORD: lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/ram_byte_array.sv
// Word-organised byte-lane storage: synchronous per-byte writes and a
// combinational word-aligned read port.
module ram_byte_array #(
    parameter int WORD_BITS = 7
) (
    input  logic                 clk,
    input  logic [3:0]           we,
    input  logic [WORD_BITS-1:0] word_addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata
);

    logic [31:0] mem [2**WORD_BITS];

    // NOTE: storage has no reset; clearing a RAM needs a sequencer, and contents must survive reset anyway.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem[word_addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[word_addr];

endmodule

// File: rtl/ram_responder.sv
// MOV/MOC memory responder: accepts one CPU access per four-phase handshake,
// inserts WAIT_STATES cycles, then completes with moc (and err on bad requests).
module ram_responder
    import mem_pkg::*;
#(
    parameter int ADDR_BITS   = 9,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        mov,
    input  logic        rw,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        moc,
    output logic        err
);

    state_e                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic                   rw_q, rw_d;
    logic [1:0]             size_q, size_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [31:0]            data_out_q, data_out_d;
    logic                   err_q, err_d;

    logic        req_err;
    logic        access;
    logic [4:0]  lane_shift;
    logic [31:0] size_keep;
    logic [31:0] mem_rdata, mem_wdata, rd_steered;
    logic [3:0]  mem_we;

    assign req_err = misaligned(size, addr[1:0]) | (|addr[31:ADDR_BITS]);
    assign access  = (state_q == BUSY) && (cnt_q == 4'd0);

    // Distance in bits between the addressed bytes and the right-justified CPU view.
    always_comb begin
        lane_shift = 5'd0;
        size_keep  = 32'hFFFF_FFFF;
        case (size_q)
            SZ_BYTE: begin
                lane_shift = {~addr_q[1:0], 3'b000};
                size_keep  = 32'h0000_00FF;
            end
            SZ_HALF: begin
                lane_shift = {~addr_q[1], 4'b0000};
                size_keep  = 32'h0000_FFFF;
            end
            default: ;
        endcase
    end

    assign rd_steered = (mem_rdata >> lane_shift) & size_keep;
    assign mem_wdata  = wdata_q << lane_shift;
    assign mem_we     = (access && rw_q == RW_WRITE) ? lane_mask(size_q, addr_q[1:0]) : 4'b0000;

    ram_byte_array #(
        .WORD_BITS(ADDR_BITS - 2)
    ) u_array (
        .clk      (clk),
        .we       (mem_we),
        .word_addr(addr_q[ADDR_BITS-1:2]),
        .wdata    (mem_wdata),
        .rdata    (mem_rdata)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        rw_d       = rw_q;
        size_d     = size_q;
        wdata_d    = wdata_q;
        data_out_d = data_out_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (enable && mov) begin
                    addr_d  = addr[ADDR_BITS-1:0];
                    rw_d    = rw;
                    size_d  = size;
                    wdata_d = data_in;
                    if (req_err) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = 4'(WAIT_STATES);
                        err_d   = 1'b0;
                    end
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    if (rw_q == RW_READ) begin
                        data_out_d = rd_steered;
                    end
                    state_d = DONE;
                    err_d   = 1'b0;
                end
            end
            DONE: begin
                if (!mov) begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            rw_q       <= RW_READ;
            size_q     <= SZ_BYTE;
            wdata_q    <= 32'd0;
            data_out_q <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            rw_q       <= rw_d;
            size_q     <= size_d;
            wdata_q    <= wdata_d;
            data_out_q <= data_out_d;
            err_q      <= err_d;
        end
    end

    assign moc      = (state_q == DONE);
    assign err      = err_q;
    assign data_out = data_out_q;

endmodule
